// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NREQ writeback sources.
// Define RF_WB_CLEAR_SEQ_EN to zero registers 1..AMOUNT-1 after every reset before granting.
module rf_wb_arbiter #(
   parameter int XLEN       = 32,
   parameter int AMOUNT     = 16,
   parameter int ADDRESSLEN = 5,
   parameter int NREQ       = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       hold,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*ADDRESSLEN-1:0] req_rd,
   input  logic [NREQ*XLEN-1:0]       req_data,
   output logic                       rf_wEn,
   output logic [ADDRESSLEN-1:0]      rf_rd,
   output logic [XLEN-1:0]            rf_data,
   output logic                       busy,
   output logic                       err_addr
);

   localparam int PW = $clog2(NREQ);

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t                state;
   logic [PW-1:0]         ptr;
   logic [PW-1:0]         grant_idx;
   logic                  grant_any;
   logic [ADDRESSLEN-1:0] sel_rd;
   logic [XLEN-1:0]       sel_data;
   logic                  in_range;
   int                    idx;

`ifdef RF_WB_CLEAR_SEQ_EN
   logic [ADDRESSLEN-1:0] cnt;
   assign busy = (state == S_CLEAR);
`else
   assign busy = 1'b0;
`endif

   // Grant stage: search from ptr upward with wrap, first valid requester wins
   always_comb begin
      req_ready = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      if (state == S_RUN && !reset && !hold) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!grant_any && req_valid[idx[PW-1:0]]) begin
               grant_any = 1'b1;
               grant_idx = idx[PW-1:0];
            end
         end
         if (grant_any) req_ready[grant_idx] = 1'b1;
      end
   end

   assign sel_rd   = req_rd[grant_idx*ADDRESSLEN +: ADDRESSLEN];
   assign sel_data = req_data[grant_idx*XLEN +: XLEN];
   assign in_range = 32'(sel_rd) < AMOUNT;

   // Write-port register stage
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_wEn   <= 1'b0;
         rf_rd    <= '0;
         rf_data  <= '0;
         err_addr <= 1'b0;
         ptr      <= '0;
`ifdef RF_WB_CLEAR_SEQ_EN
         state    <= S_CLEAR;
         cnt      <= ADDRESSLEN'(1);
`else
         state    <= S_RUN;
`endif
      end else if (state == S_RUN) begin
         if (grant_any) begin
            ptr     <= (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);
            // x0 and out-of-range addresses are consumed but never written
            rf_wEn  <= (sel_rd != '0) && in_range;
            rf_rd   <= sel_rd;
            rf_data <= sel_data;
            if (!in_range) err_addr <= 1'b1;
         end else begin
            rf_wEn  <= 1'b0;
         end
      end
`ifdef RF_WB_CLEAR_SEQ_EN
      else begin
         rf_wEn  <= 1'b1;
         rf_rd   <= cnt;
         rf_data <= '0;
         if (cnt == ADDRESSLEN'(AMOUNT-1)) state <= S_RUN;
         else                              cnt   <= cnt + ADDRESSLEN'(1);
      end
`endif
   end

endmodule
